// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB, one instruction in flight.
// Optional CTRL_PERF_EN adds free-running cycle_count and retired instr_count outputs.
module mips_multicycle_ctrl #(
  parameter int ALUOP_W = 8,
  parameter int OPC_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               branch_taken,
  output logic               jump_taken,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_wren,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic               busy,
`ifdef CTRL_PERF_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count,
`endif
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_RTYPE = 3'd1,
    C_ADDI  = 3'd2,
    C_LW    = 3'd3,
    C_SW    = 3'd4,
    C_BEQ   = 3'd5,
    C_J     = 3'd6
  } iclass_t;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_J     = 6'h02;

  localparam logic [OPC_W-1:0] FN_ADD = 6'h20;
  localparam logic [OPC_W-1:0] FN_SUB = 6'h22;
  localparam logic [OPC_W-1:0] FN_AND = 6'h24;
  localparam logic [OPC_W-1:0] FN_OR  = 6'h25;
  localparam logic [OPC_W-1:0] FN_XOR = 6'h26;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b101;

  state_t           state, next_state;
  logic [OPC_W-1:0] opc_q, funct_q;
  iclass_t          iclass;
  logic [2:0]       rtype_op;
  logic             rtype_ok;
  logic [2:0]       op3;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      opc_q   <= '0;
      funct_q <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) begin
        opc_q   <= instr[31:26];
        funct_q <= instr[5:0];
      end
    end
  end

  always_comb begin
    rtype_op = OP_ADD;
    rtype_ok = 1'b1;
    case (funct_q)
      FN_ADD:  rtype_op = OP_ADD;
      FN_SUB:  rtype_op = OP_SUB;
      FN_AND:  rtype_op = OP_AND;
      FN_OR:   rtype_op = OP_OR;
      FN_XOR:  rtype_op = OP_XOR;
      default: rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    iclass = C_NONE;
    case (opc_q)
      OPC_RTYPE: iclass = rtype_ok ? C_RTYPE : C_NONE;
      OPC_ADDI:  iclass = C_ADDI;
      OPC_LW:    iclass = C_LW;
      OPC_SW:    iclass = C_SW;
      OPC_BEQ:   iclass = C_BEQ;
      OPC_J:     iclass = C_J;
      default:   iclass = C_NONE;
    endcase
  end

  always_comb begin
    next_state   = state;
    pc_en        = 1'b0;
    branch_taken = 1'b0;
    jump_taken   = 1'b0;
    op3          = OP_ADD;
    alu_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_wren     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;
    busy         = (state != S_FETCH);
    case (state)
      S_FETCH: begin
        pc_en      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (iclass == C_NONE) begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (iclass)
          C_RTYPE: begin
            op3        = rtype_op;
            next_state = S_WB;
          end
          C_ADDI: begin
            alu_src    = 1'b1;
            next_state = S_WB;
          end
          C_LW, C_SW: begin
            alu_src    = 1'b1;
            next_state = S_MEM;
          end
          C_BEQ: begin
            op3          = OP_SUB;
            branch_taken = zero;
            next_state   = S_FETCH;
          end
          default: begin
            jump_taken = (iclass == C_J);
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = (iclass == C_LW);
        mem_write = (iclass == C_SW);
        if (mem_ready) next_state = (iclass == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        // ALU controls stay steady so an unregistered ALU result remains valid at writeback
        op3        = (iclass == C_RTYPE) ? rtype_op : OP_ADD;
        alu_src    = (iclass != C_RTYPE);
        reg_wren   = 1'b1;
        reg_dst    = (iclass == C_RTYPE);
        mem_to_reg = (iclass == C_LW);
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset forces every control output quiet, even before the state register settles
    if (reset) begin
      pc_en        = 1'b0;
      branch_taken = 1'b0;
      jump_taken   = 1'b0;
      op3          = OP_ADD;
      alu_src      = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_wren     = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      illegal      = 1'b0;
      busy         = 1'b0;
    end
  end

  assign alu_op = {{(ALUOP_W-3){1'b0}}, op3};

`ifdef CTRL_PERF_EN
  logic retire;
  assign retire = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_DECODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle expected control vectors from an
// instruction-level model are queued as each cycle is driven and compared at the falling edge.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, branch_taken, jump_taken;
  logic [7:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_wren, reg_dst, mem_to_reg, illegal, busy;
  logic [2:0]  state_dbg;
`ifdef CTRL_PERF_EN
  logic [31:0] cycle_count, instr_count;
  logic [31:0] exp_cyc, exp_ins;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.ALUOP_W(8), .OPC_W(6)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .branch_taken(branch_taken), .jump_taken(jump_taken),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .reg_wren(reg_wren), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .busy(busy),
`ifdef CTRL_PERF_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {pc_en, branch, jump, alu_op[7:0], alu_src, mem_read, mem_write, reg_wren, reg_dst, mem_to_reg, illegal, busy}
  function automatic logic [18:0] vec(input logic pc, input logic br, input logic jp,
                                      input logic [2:0] op, input logic src, input logic mrd,
                                      input logic mwr, input logic wr, input logic dst,
                                      input logic m2r, input logic ill, input logic bsy);
    return {pc, br, jp, 5'b0, op, src, mrd, mwr, wr, dst, m2r, ill, bsy};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {pc_en, branch_taken, jump_taken, alu_op, alu_src, mem_read, mem_write,
            reg_wren, reg_dst, mem_to_reg, illegal, busy};
  endfunction

  // class: 0 illegal, 1 R, 2 ADDI, 3 LW, 4 SW, 5 BEQ, 6 J
  function automatic int cls_of(input logic [31:0] i, output logic [2:0] rop);
    rop = 3'b000;
    case (i[31:26])
      6'h00: begin
        case (i[5:0])
          6'h20: begin rop = 3'b000; return 1; end
          6'h22: begin rop = 3'b001; return 1; end
          6'h24: begin rop = 3'b010; return 1; end
          6'h25: begin rop = 3'b011; return 1; end
          6'h26: begin rop = 3'b101; return 1; end
          default: return 0;
        endcase
      end
      6'h08: return 2;
      6'h23: return 3;
      6'h2B: return 4;
      6'h04: return 5;
      6'h02: return 6;
      default: return 0;
    endcase
  endfunction

  // phases: 0 fetch, 1 decode, 2 exec, 3 mem wait, 4 mem ready, 5 wb, 6 reset
  task automatic run_instr(input string name, input logic [31:0] i, input logic z,
                           input int waits, input int reset_at);
    logic [18:0] ev[$];
    int          ph[$];
    logic [2:0]  rop;
    logic [18:0] e, tmp;
    int          c;
    c = cls_of(i, rop);
    ev.push_back(vec(1,0,0,3'd0,0,0,0,0,0,0,0,0)); ph.push_back(0);
    ev.push_back(vec(0,0,0,3'd0,0,0,0,0,0,0,(c == 0),1)); ph.push_back(1);
    case (c)
      1: begin
        ev.push_back(vec(0,0,0,rop,0,0,0,0,0,0,0,1)); ph.push_back(2);
        ev.push_back(vec(0,0,0,rop,0,0,0,1,1,0,0,1)); ph.push_back(5);
      end
      2: begin
        ev.push_back(vec(0,0,0,3'd0,1,0,0,0,0,0,0,1)); ph.push_back(2);
        ev.push_back(vec(0,0,0,3'd0,1,0,0,1,0,0,0,1)); ph.push_back(5);
      end
      3, 4: begin
        ev.push_back(vec(0,0,0,3'd0,1,0,0,0,0,0,0,1)); ph.push_back(2);
        for (int w = 0; w <= waits; w++) begin
          ev.push_back(vec(0,0,0,3'd0,1,(c == 3),(c == 4),0,0,0,0,1));
          ph.push_back((w < waits) ? 3 : 4);
        end
        if (c == 3) begin
          ev.push_back(vec(0,0,0,3'd0,1,0,0,1,0,1,0,1)); ph.push_back(5);
        end
      end
      5: begin
        ev.push_back(vec(0,z,0,3'd1,0,0,0,0,0,0,0,1)); ph.push_back(2);
      end
      6: begin
        ev.push_back(vec(0,0,1,3'd0,0,0,0,0,0,0,0,1)); ph.push_back(2);
      end
      default: ;
    endcase
    if (reset_at >= 0 && reset_at < ev.size()) begin
      while (ev.size() > reset_at) begin
        tmp = ev.pop_back();
        void'(ph.pop_back());
      end
      ev.push_back(19'd0); ph.push_back(6);
    end
    for (int k = 0; k < ev.size(); k++) begin
      instr     = (ph[k] == 0) ? i : $urandom;
      zero      = (ph[k] == 2) ? z : 1'($urandom_range(0, 1));
      mem_ready = (ph[k] == 3) ? 1'b0 : (ph[k] == 4) ? 1'b1 : 1'($urandom_range(0, 1));
      reset     = (ph[k] == 6);
      exp_q.push_back(ev[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s.c%0d", name, k), 32'(dut_vec()), 32'(e));
`ifdef CTRL_PERF_EN
      check($sformatf("%s.cyc%0d", name, k), cycle_count, exp_cyc);
      check($sformatf("%s.ins%0d", name, k), instr_count, exp_ins);
      if (ph[k] == 6) begin
        exp_cyc = 0;
        exp_ins = 0;
      end else begin
        exp_cyc++;
        if (k == ev.size() - 1 && c != 0) exp_ins++;
      end
`endif
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    logic [5:0]  fn[5];
    r = $urandom;
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    case ($urandom_range(0, 5))
      0: return {6'h00, r[25:6], fn[$urandom_range(0, 4)]};
      1: return {6'h08, r[25:0]};
      2: return {6'h23, r[25:0]};
      3: return {6'h2B, r[25:0]};
      4: return {6'h04, r[25:0]};
      default: return {6'h02, r[25:0]};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] e;
    reset     = 1'b1;
    instr     = 32'h0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(19'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("reset.c%0d", k), 32'(dut_vec()), 32'(e));
      @(posedge clk);
      #1;
    end
    check("reset.state", 32'(state_dbg), 32'd0);
`ifdef CTRL_PERF_EN
    check("reset.cyc", cycle_count, 32'd0);
    check("reset.ins", instr_count, 32'd0);
    exp_cyc = 0;
    exp_ins = 0;
`endif
    reset = 1'b0;

    run_instr("add",      32'h00221820, 1'b0, 0, -1);
    run_instr("sub",      32'h00221822, 1'b0, 0, -1);
    run_instr("and",      32'h00221824, 1'b0, 0, -1);
    run_instr("or",       32'h00221825, 1'b0, 0, -1);
    run_instr("xor",      32'h00221826, 1'b0, 0, -1);
    run_instr("addi",     32'h20220005, 1'b0, 0, -1);
    run_instr("lw_wait2", 32'h8C230004, 1'b0, 2, -1);
    run_instr("sw_wait1", 32'hAC230004, 1'b0, 1, -1);
    run_instr("beq_z1",   32'h10220003, 1'b1, 0, -1);
    run_instr("beq_z0",   32'h10220003, 1'b0, 0, -1);
    run_instr("j",        32'h08000010, 1'b0, 0, -1);
    run_instr("ill_opc",  32'hFC000000, 1'b0, 0, -1);
    run_instr("ill_fn",   32'h00221821, 1'b0, 0, -1);
    run_instr("sw_rst",   32'hAC230004, 1'b0, 3, 4);
    run_instr("add_after",32'h00221820, 1'b0, 0, -1);
    run_instr("lw_rstwb", 32'h8C230004, 1'b0, 0, 4);
    run_instr("lw_nowait",32'h8C230004, 1'b0, 0, -1);
    for (int n = 0; n < 25; n++)
      run_instr($sformatf("rnd%0d", n), rand_legal(), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
